register_file: RTL and testbench
================================

Name: register_file

Overview:
- Datapath register bank for the multicore processor core: AR, DR, PC, IR, R1–R7 and AC, each 16 bits.
- Registers are written from the shared B-bus, from instruction memory (IR) or from data memory (DR).
- One register at a time drives the B-bus back out; AR/PC/DR/IR/AC drive memory, the ALU and the control unit directly.
- Sits between the control unit (which supplies the strobes) and the ALU/memories.

Parameters:
WIDTH, 16, data/register width (all buses and registers).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- MEMREAD  in  1  load DR from DIN
- WAR,WDR,WPC,WIR,WR1..WR7,WAC  in  1 each  register write enables
- RAR,RDR,RPC,RIR,RR1..RR7,RAC  in  1 each  B-bus read selects
- LDALUIR,LDALUIDX,LDALUIDY,LDALUR1,LDALUR5  in  1 each  ALU B-operand load strobes
- LDALUAC  in  1  ALU A-operand (AC) strobe
- RSTR1..RSTR7  in  1 each  clear Rn
- R2INC  in  1  increment R2
- PCINC  in  1  increment PC
- ALUMUX  in  3  ALU B-operand source select
- INSIN  in  16  instruction from instruction memory
- DIN  in  16  data from data memory
- BIN  in  16  B-bus write data
- DMADDR  out  16  data-memory address (= AR)
- IMADDR  out  16  instruction-memory address (= PC)
- DOUT  out  16  data-memory write data (= DR)
- ACOUT  out  16  ALU A-operand
- ALUOUT  out  16  ALU B-operand
- BOUT  out  16  B-bus read data
- IROUT  out  16  IR to control unit

Behaviour:
- Sequential updates happen only on posedge clk.
- rst=1: every register becomes 0 at the edge; this overrides all other strobes.
- Plain writes at the edge:
  - WAR: AR<=BIN; WPC: PC<=BIN; WRn: Rn<=BIN; WAC: AC<=BIN.
  - WIR: IR<=INSIN.
- DR: MEMREAD=1 gives DR<=DIN; otherwise WDR=1 gives DR<=BIN. MEMREAD has priority.
- PC priority: WPC > PCINC. PCINC gives PC<=PC+1, modulo 2^16 (0xFFFF -> 0x0000).
- R2 priority: RSTR2 > WR2 > R2INC. R2INC gives R2<=R2+1, wrapping modulo 2^16.
- Other Rn: RSTRn > WRn.
- Registers with no active strobe hold their value.
- Combinational outputs, zero latency, glitch-free from register values:
  - DMADDR=AR, IMADDR=PC, DOUT=DR, IROUT=IR.
- BOUT: fixed-priority mux. The first asserted select in the order RAR, RDR, RPC, RIR, RR1..RR7, RAC drives its register; with none asserted, BOUT=0.
- ACOUT = AC when LDALUAC=1, else 0.
- ALUOUT:
  - When any of LDALUIR, LDALUIDX, LDALUIDY, LDALUR1, LDALUR5 =1, ALUOUT = mux(ALUMUX); otherwise 0.
  - mux(ALUMUX): 000 gives 0, 001 IR, 010 R2 (IDX), 011 R3 (IDY), 100 R1, 101 R5, 110/111 give 0.
- A read in the same cycle as a write returns the old value until the edge; the new value appears immediately after the edge.
- After reset, all outputs are 0.
- Reset asserted mid-operation: the reset takes effect at the next edge, regardless of pending strobes.

Decomposition:
- Shared package holds:
  - WIDTH;
  - ALUMUX encodings ALU_SEL_NONE/IR/IDX/IDY/R1/R5;
  - BOUT select priority order.
- One natural sub-module is gen_reg: a WIDTH-bit register with rst, clr, wr/d and inc inputs, using the priority rst>clr>wr>inc. Instantiate it 12 times; for registers without clr/inc, tie those inputs to 0.

Test Plan:
- rst=1 for one edge -> BOUT (every select), DMADDR, IMADDR, DOUT, IROUT all 0.
- Write/read paths:
  - BIN=12, WAC, edge, then RAC -> BOUT=12.
  - BIN=20, WAR, edge -> DMADDR=20.
  - BIN=24, WDR, edge -> RDR gives BOUT=24 and DOUT=24.
  - LDALUAC -> ACOUT=12 without a clock edge.
- IR and ALU operand:
  - INSIN=212, WIR, edge -> RIR gives BOUT=212; IROUT=212.
  - LDALUIR with ALUMUX=001 -> ALUOUT=212.
  - R1=228, LDALUR1 with ALUMUX=100 -> ALUOUT=228.
- PC and R2 increment:
  - BIN=220, WPC, edge, then PCINC for one edge -> IMADDR=221.
  - R2=224, R2INC for one edge -> RR2 gives BOUT=225.
  - PC=0xFFFF with PCINC -> 0.
- Clear: RSTR1/RSTR2/RSTR3 one edge each -> corresponding RRn gives BOUT=0. RSTR2 with WR2 in the same cycle -> R2=0.
- Priority:
  - MEMREAD with DIN=5, plus WDR with BIN=9 -> DR=5.
  - RAR and RAC both asserted -> BOUT=AR.
  - No selects -> BOUT=0.

Source files
------------

// File: rtl/register_file_pkg.sv
// rtl/register_file_pkg.sv - shared widths, ALU operand encodings and B-bus select order
package register_file_pkg;

  localparam int WIDTH = 16;

  // ALU B-operand source encodings
  localparam logic [2:0] ALU_SEL_NONE = 3'b000;
  localparam logic [2:0] ALU_SEL_IR   = 3'b001;
  localparam logic [2:0] ALU_SEL_IDX  = 3'b010;
  localparam logic [2:0] ALU_SEL_IDY  = 3'b011;
  localparam logic [2:0] ALU_SEL_R1   = 3'b100;
  localparam logic [2:0] ALU_SEL_R5   = 3'b101;

  // Register indices; lower index wins when several B-bus selects are active
  typedef enum int {
    REG_AR = 0,
    REG_DR = 1,
    REG_PC = 2,
    REG_IR = 3,
    REG_R1 = 4,
    REG_R2 = 5,
    REG_R3 = 6,
    REG_R4 = 7,
    REG_R5 = 8,
    REG_R6 = 9,
    REG_R7 = 10,
    REG_AC = 11
  } reg_idx_e;

  localparam int NUM_REGS = 12;

endpackage

// File: rtl/register_file_gen_reg.sv
// rtl/register_file_gen_reg.sv - generic register with reset, clear, load and increment
module register_file_gen_reg
  import register_file_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] d,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Priority rst > clr > wr > inc; increment wraps naturally at 2^W
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (wr)  q <= d;
    else if (inc) q <= q + ONE;
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - datapath register bank with B-bus, memory and ALU operand ports
module register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH = register_file_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEMREAD,
  input  logic             WAR, WDR, WPC, WIR,
  input  logic             WR1, WR2, WR3, WR4, WR5, WR6, WR7,
  input  logic             WAC,
  input  logic             RAR, RDR, RPC, RIR,
  input  logic             RR1, RR2, RR3, RR4, RR5, RR6, RR7,
  input  logic             RAC,
  input  logic             LDALUIR, LDALUIDX, LDALUIDY, LDALUR1, LDALUR5,
  input  logic             LDALUAC,
  input  logic             RSTR1, RSTR2, RSTR3, RSTR4, RSTR5, RSTR6, RSTR7,
  input  logic             R2INC,
  input  logic             PCINC,
  input  logic [2:0]       ALUMUX,
  input  logic [WIDTH-1:0] INSIN,
  input  logic [WIDTH-1:0] DIN,
  input  logic [WIDTH-1:0] BIN,
  output logic [WIDTH-1:0] DMADDR,
  output logic [WIDTH-1:0] IMADDR,
  output logic [WIDTH-1:0] DOUT,
  output logic [WIDTH-1:0] ACOUT,
  output logic [WIDTH-1:0] ALUOUT,
  output logic [WIDTH-1:0] BOUT,
  output logic [WIDTH-1:0] IROUT
);

  logic [NUM_REGS-1:0] wr_en;
  logic [NUM_REGS-1:0] clr_en;
  logic [NUM_REGS-1:0] inc_en;
  logic [NUM_REGS-1:0] rd_sel;
  logic [WIDTH-1:0]    wr_data [NUM_REGS];
  logic [WIDTH-1:0]    regs    [NUM_REGS];

  // Strobes gathered into vectors indexed in B-bus priority order
  assign wr_en  = {WAC, WR7, WR6, WR5, WR4, WR3, WR2, WR1, WIR, WPC, WDR | MEMREAD, WAR};
  assign clr_en = {1'b0, RSTR7, RSTR6, RSTR5, RSTR4, RSTR3, RSTR2, RSTR1, 4'b0000};
  assign inc_en = {6'b000000, R2INC, 2'b00, PCINC, 2'b00};
  assign rd_sel = {RAC, RR7, RR6, RR5, RR4, RR3, RR2, RR1, RIR, RPC, RDR, RAR};

  // Write data per register: IR from instruction memory, DR prefers data memory
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) wr_data[i] = BIN;
    wr_data[REG_IR] = INSIN;
    wr_data[REG_DR] = MEMREAD ? DIN : BIN;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_REGS; g++) begin : g_reg
      register_file_gen_reg #(.W(WIDTH)) u_reg (
        .clk (clk),
        .rst (rst),
        .clr (clr_en[g]),
        .wr  (wr_en[g]),
        .d   (wr_data[g]),
        .inc (inc_en[g]),
        .q   (regs[g])
      );
    end
  endgenerate

  assign DMADDR = regs[REG_AR];
  assign IMADDR = regs[REG_PC];
  assign DOUT   = regs[REG_DR];
  assign IROUT  = regs[REG_IR];
  assign ACOUT  = LDALUAC ? regs[REG_AC] : '0;

  // B-bus: scan from lowest priority upward so the lowest active index wins
  always_comb begin
    BOUT = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (rd_sel[i]) BOUT = regs[i];
    end
  end

  // ALU B-operand: only driven while one of the operand load strobes is active
  always_comb begin
    ALUOUT = '0;
    if (LDALUIR | LDALUIDX | LDALUIDY | LDALUR1 | LDALUR5) begin
      case (ALUMUX)
        ALU_SEL_IR:  ALUOUT = regs[REG_IR];
        ALU_SEL_IDX: ALUOUT = regs[REG_R2];
        ALU_SEL_IDY: ALUOUT = regs[REG_R3];
        ALU_SEL_R1:  ALUOUT = regs[REG_R1];
        ALU_SEL_R5:  ALUOUT = regs[REG_R5];
        default:     ALUOUT = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - table-driven scoreboard bench for register_file
module tb_register_file;

  localparam logic [11:0] M_AR = 12'h001, M_DR = 12'h002, M_PC = 12'h004, M_IR = 12'h008;
  localparam logic [11:0] M_R1 = 12'h010, M_R2 = 12'h020, M_R3 = 12'h040, M_R5 = 12'h100;
  localparam logic [11:0] M_R7 = 12'h400, M_AC = 12'h800;
  localparam logic [5:0]  L_IR = 6'h01, L_IDX = 6'h02, L_IDY = 6'h04, L_R1 = 6'h08, L_R5 = 6'h10, L_AC = 6'h20;

  typedef struct {
    string       name;
    bit          edge_en;
    logic [11:0] wr;
    logic [15:0] bin;
    logic [15:0] din;
    logic [15:0] ins;
    logic        memread;
    logic        pcinc;
    logic        r2inc;
    logic [6:0]  rstr;
    logic [11:0] rd;
    logic [5:0]  ld;
    logic [2:0]  mux;
    logic [15:0] exp_bout;
    logic [15:0] exp_acout;
    logic [15:0] exp_aluout;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] bout;
    logic [15:0] acout;
    logic [15:0] aluout;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memread = 1'b0, pcinc = 1'b0, r2inc = 1'b0;
  logic [11:0] wr = '0, rd = '0;
  logic [6:0]  rstr = '0;
  logic [5:0]  ld = '0;
  logic [2:0]  mux = '0;
  logic [15:0] bin = '0, din = '0, ins = '0;
  logic [15:0] dmaddr, imaddr, dout, acout, aluout, bout, irout;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];
  exp_t sb[$];

  register_file dut (
    .clk(clk), .rst(rst), .MEMREAD(memread),
    .WAR(wr[0]), .WDR(wr[1]), .WPC(wr[2]), .WIR(wr[3]),
    .WR1(wr[4]), .WR2(wr[5]), .WR3(wr[6]), .WR4(wr[7]), .WR5(wr[8]), .WR6(wr[9]), .WR7(wr[10]),
    .WAC(wr[11]),
    .RAR(rd[0]), .RDR(rd[1]), .RPC(rd[2]), .RIR(rd[3]),
    .RR1(rd[4]), .RR2(rd[5]), .RR3(rd[6]), .RR4(rd[7]), .RR5(rd[8]), .RR6(rd[9]), .RR7(rd[10]),
    .RAC(rd[11]),
    .LDALUIR(ld[0]), .LDALUIDX(ld[1]), .LDALUIDY(ld[2]), .LDALUR1(ld[3]), .LDALUR5(ld[4]),
    .LDALUAC(ld[5]),
    .RSTR1(rstr[0]), .RSTR2(rstr[1]), .RSTR3(rstr[2]), .RSTR4(rstr[3]), .RSTR5(rstr[4]),
    .RSTR6(rstr[5]), .RSTR7(rstr[6]),
    .R2INC(r2inc), .PCINC(pcinc), .ALUMUX(mux),
    .INSIN(ins), .DIN(din), .BIN(bin),
    .DMADDR(dmaddr), .IMADDR(imaddr), .DOUT(dout), .ACOUT(acout),
    .ALUOUT(aluout), .BOUT(bout), .IROUT(irout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input bit e, input logic [11:0] w, input logic [15:0] b,
                     input logic [15:0] d, input logic [15:0] i, input logic mr, input logic pci,
                     input logic r2i, input logic [6:0] rs, input logic [11:0] r,
                     input logic [5:0] l, input logic [2:0] m, input logic [15:0] eb,
                     input logic [15:0] ea, input logic [15:0] eal);
    vec_t v;
    v.name = n; v.edge_en = e; v.wr = w; v.bin = b; v.din = d; v.ins = i;
    v.memread = mr; v.pcinc = pci; v.r2inc = r2i; v.rstr = rs; v.rd = r; v.ld = l; v.mux = m;
    v.exp_bout = eb; v.exp_acout = ea; v.exp_aluout = eal;
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    wr = '0; rd = '0; ld = '0; rstr = '0; mux = '0;
    memread = 1'b0; pcinc = 1'b0; r2inc = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 12; i++) begin
      rd = 12'(1) << i;
      #1;
      chk($sformatf("%s_bout_sel%0d", tag, i), bout, 16'h0);
    end
    rd = '0;
    ld = 6'h3f;
    for (int m = 0; m < 8; m++) begin
      mux = 3'(m);
      #1;
      chk($sformatf("%s_aluout_mux%0d", tag, m), aluout, 16'h0);
    end
    chk({tag, "_acout"}, acout, 16'h0);
    ld = '0; mux = '0;
    chk({tag, "_dmaddr"}, dmaddr, 16'h0);
    chk({tag, "_imaddr"}, imaddr, 16'h0);
    chk({tag, "_dout"}, dout, 16'h0);
    chk({tag, "_irout"}, irout, 16'h0);
  endtask

  initial begin
    exp_t e;

    //  name         edge wr    bin      din   ins   mr pci r2i rstr    rd         ld    mux  bout     acout aluout
    add("wac",       1, M_AC, 16'd12,  16'd0, 16'd0,   0, 0, 0, 7'h00, M_AC,      6'h0, 3'd0, 16'd12,  16'd0, 16'd0);
    add("war",       1, M_AR, 16'd20,  16'd0, 16'd0,   0, 0, 0, 7'h00, M_AR,      6'h0, 3'd0, 16'd20,  16'd0, 16'd0);
    add("wdr",       1, M_DR, 16'd24,  16'd0, 16'd0,   0, 0, 0, 7'h00, M_DR,      6'h0, 3'd0, 16'd24,  16'd0, 16'd0);
    add("acout",     0, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h00, 12'h0,     L_AC, 3'd0, 16'd0,   16'd12,16'd0);
    add("wir",       1, M_IR, 16'd0,   16'd0, 16'd212, 0, 0, 0, 7'h00, M_IR,      6'h0, 3'd0, 16'd212, 16'd0, 16'd0);
    add("alu_ir",    0, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h00, 12'h0,     L_IR, 3'd1, 16'd0,   16'd0, 16'd212);
    add("alu_r1",    1, M_R1, 16'd228, 16'd0, 16'd0,   0, 0, 0, 7'h00, 12'h0,     L_R1, 3'd4, 16'd0,   16'd0, 16'd228);
    add("wpc",       1, M_PC, 16'd220, 16'd0, 16'd0,   0, 0, 0, 7'h00, M_PC,      6'h0, 3'd0, 16'd220, 16'd0, 16'd0);
    add("pcinc",     1, 12'h0,16'd0,   16'd0, 16'd0,   0, 1, 0, 7'h00, M_PC,      6'h0, 3'd0, 16'd221, 16'd0, 16'd0);
    add("wr2",       1, M_R2, 16'd224, 16'd0, 16'd0,   0, 0, 0, 7'h00, M_R2,      6'h0, 3'd0, 16'd224, 16'd0, 16'd0);
    add("r2inc",     1, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 1, 7'h00, M_R2,      6'h0, 3'd0, 16'd225, 16'd0, 16'd0);
    add("alu_idx",   0, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h00, 12'h0,     L_IDX,3'd2, 16'd0,   16'd0, 16'd225);
    add("wr3",       1, M_R3, 16'd77,  16'd0, 16'd0,   0, 0, 0, 7'h00, M_R3,      6'h0, 3'd0, 16'd77,  16'd0, 16'd0);
    add("alu_idy",   0, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h00, 12'h0,     L_IDY,3'd3, 16'd0,   16'd0, 16'd77);
    add("alu_r5",    1, M_R5, 16'd55,  16'd0, 16'd0,   0, 0, 0, 7'h00, 12'h0,     L_R5, 3'd5, 16'd0,   16'd0, 16'd55);
    add("alu_mux6",  0, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h00, 12'h0,     L_R1, 3'd6, 16'd0,   16'd0, 16'd0);
    add("alu_noload",0, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h00, 12'h0,     6'h0, 3'd4, 16'd0,   16'd0, 16'd0);
    add("rstr1",     1, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h01, M_R1,      6'h0, 3'd0, 16'd0,   16'd0, 16'd0);
    add("rstr2_wr2", 1, M_R2, 16'd99,  16'd0, 16'd0,   0, 0, 1, 7'h02, M_R2,      6'h0, 3'd0, 16'd0,   16'd0, 16'd0);
    add("rstr3",     1, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h04, M_R3,      6'h0, 3'd0, 16'd0,   16'd0, 16'd0);
    add("memrd_pri", 1, M_DR, 16'd9,   16'd5, 16'd0,   1, 0, 0, 7'h00, M_DR,      6'h0, 3'd0, 16'd5,   16'd0, 16'd0);
    add("rar_rac",   0, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h00, M_AR|M_AC, 6'h0, 3'd0, 16'd20,  16'd0, 16'd0);
    add("no_sel",    0, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h00, 12'h0,     6'h0, 3'd0, 16'd0,   16'd0, 16'd0);
    add("r7_over_ac",1, M_R7, 16'h1234,16'd0, 16'd0,   0, 0, 0, 7'h00, M_R7|M_AC, 6'h0, 3'd0, 16'h1234,16'd0, 16'd0);
    add("wpc_max",   1, M_PC, 16'hffff,16'd0, 16'd0,   0, 0, 0, 7'h00, M_PC,      6'h0, 3'd0, 16'hffff,16'd0, 16'd0);
    add("pc_wrap",   1, 12'h0,16'd0,   16'd0, 16'd0,   0, 1, 0, 7'h00, M_PC,      6'h0, 3'd0, 16'd0,   16'd0, 16'd0);
    add("wpc_over_inc",1,M_PC,16'd40,  16'd0, 16'd0,   0, 1, 0, 7'h00, M_PC,      6'h0, 3'd0, 16'd40,  16'd0, 16'd0);
    add("hold_ac",   1, 12'h0,16'd0,   16'd0, 16'd0,   0, 0, 0, 7'h00, M_AC,      L_AC, 3'd0, 16'd12,  16'd12,16'd0);

    // Reset for one edge
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    foreach (vecs[k]) begin
      @(negedge clk);
      clear_inputs();
      wr = vecs[k].wr; bin = vecs[k].bin; din = vecs[k].din; ins = vecs[k].ins;
      memread = vecs[k].memread; pcinc = vecs[k].pcinc; r2inc = vecs[k].r2inc; rstr = vecs[k].rstr;
      if (vecs[k].edge_en) @(posedge clk);
      #1;
      clear_inputs();
      rd = vecs[k].rd; ld = vecs[k].ld; mux = vecs[k].mux;
      e.name = vecs[k].name; e.bout = vecs[k].exp_bout;
      e.acout = vecs[k].exp_acout; e.aluout = vecs[k].exp_aluout;
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      chk({e.name, "_bout"}, bout, e.bout);
      chk({e.name, "_acout"}, acout, e.acout);
      chk({e.name, "_aluout"}, aluout, e.aluout);
    end
    clear_inputs();

    // Direct memory/control-unit ports after the table
    #1;
    chk("dmaddr_ar", dmaddr, 16'd20);
    chk("dout_dr", dout, 16'd5);
    chk("irout_ir", irout, 16'd212);
    chk("imaddr_pc", imaddr, 16'd40);

    // Read during write returns old value until the edge
    @(negedge clk);
    wr = M_AC; bin = 16'd500; rd = M_AC; ld = L_AC;
    #1;
    chk("rdw_old_bout", bout, 16'd12);
    chk("rdw_old_acout", acout, 16'd12);
    @(posedge clk);
    #1;
    wr = '0;
    chk("rdw_new_bout", bout, 16'd500);
    chk("rdw_new_acout", acout, 16'd500);
    clear_inputs();

    // Reset overrides every pending strobe
    @(negedge clk);
    rst = 1'b1; wr = 12'hfff; bin = 16'hbeef; din = 16'h1111; ins = 16'h2222;
    memread = 1'b1; pcinc = 1'b1; r2inc = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    check_all_zero("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
